// File: rtl/rs5_wb_data_bridge.sv
// RS5 data-memory port to Wishbone classic master bridge.
// Turns a single-cycle core request into one Wishbone read or write cycle and stalls the core
// until the slave acks. A missing ack is bounded by a timeout that returns ERR_DATA and an error
// pulse instead of hanging the core.
module rs5_wb_data_bridge #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // Core side
  input  logic                    core_req_i,
  input  logic [DATA_WIDTH/8-1:0] core_we_i,
  input  logic [ADDR_WIDTH-1:0]   core_addr_i,
  input  logic [DATA_WIDTH-1:0]   core_wdata_i,
  output logic [DATA_WIDTH-1:0]   core_rdata_o,
  output logic                    core_stall_o,
  output logic                    core_err_o,
  // Wishbone side
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i
);

  localparam int unsigned Lanes    = DATA_WIDTH / 8;
  localparam int unsigned CntW     = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CntLimit = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CntLimit);
  localparam bit TimeoutEn = (TIMEOUT_CYCLES != 0);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBus  = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [Lanes-1:0]      sel_q, sel_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  stall;

  // Next-state, bus-capture and stall logic for the IDLE -> BUS -> RESP handshake.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    case (state_q)
      StIdle: begin
        // Masked by reset so the core is never stalled while the bridge is held in reset.
        stall = core_req_i & rst_n;
        if (core_req_i) begin
          state_d = StBus;
          cyc_d   = 1'b1;
          we_d    = |core_we_i;
          sel_d   = (|core_we_i) ? core_we_i : {Lanes{1'b1}};
          adr_d   = core_addr_i;
          dat_d   = core_wdata_i;
          cnt_d   = '0;
        end
      end
      StBus: begin
        stall = 1'b1;
        cnt_d = cnt_q + CntW'(1);
        // Ack takes priority over a timeout landing in the same cycle.
        if (wb_ack_i) begin
          state_d = StResp;
          cyc_d   = 1'b0;
          if (!we_q) rdata_d = wb_dat_i;
        end else if (TimeoutEn && (cnt_q == CntMax)) begin
          state_d = StResp;
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          if (!we_q) rdata_d = ERR_DATA;
        end
      end
      StResp: begin
        // Requests seen here are picked up again from IDLE on the next cycle.
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cyc_d   = 1'b0;
      end
    endcase
  end

  // State and registered bus/core outputs; reset drops the bus cycle immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = we_q;
  assign wb_sel_o     = sel_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign core_rdata_o = rdata_q;
  assign core_err_o   = err_q;
  assign core_stall_o = stall;

endmodule

// File: tb/tb_rs5_wb_data_bridge.sv
// Self-checking bench for rs5_wb_data_bridge.
// Two bridges with timeouts of 8 and 4 cycles share all inputs; a transaction-level model
// predicts for each one how long the bus cycle lasts, whether it times out, and what read data
// the core sees.
module tb_rs5_wb_data_bridge;

  localparam int unsigned TmoA = 8;
  localparam int unsigned TmoB = 4;
  localparam logic [31:0] ErrData = 32'hDEADBEEF;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [3:0]  we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] dat_i;
  logic        ack;

  logic [31:0] rdata_o [2];
  logic        stall_o [2];
  logic        err_o   [2];
  logic        cyc_o   [2];
  logic        stb_o   [2];
  logic        wbwe_o  [2];
  logic [3:0]  sel_o   [2];
  logic [31:0] adr_o   [2];
  logic [31:0] dat_o   [2];

  int          nchk;
  int          nfail;
  int unsigned tmo [2];
  logic [31:0] rd_m [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    rs5_wb_data_bridge #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES((g == 0) ? TmoA : TmoB),
      .ERR_DATA      (ErrData)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .core_req_i  (req),
      .core_we_i   (we),
      .core_addr_i (addr),
      .core_wdata_i(wdata),
      .core_rdata_o(rdata_o[g]),
      .core_stall_o(stall_o[g]),
      .core_err_o  (err_o[g]),
      .wb_cyc_o    (cyc_o[g]),
      .wb_stb_o    (stb_o[g]),
      .wb_we_o     (wbwe_o[g]),
      .wb_sel_o    (sel_o[g]),
      .wb_adr_o    (adr_o[g]),
      .wb_dat_o    (dat_o[g]),
      .wb_dat_i    (dat_i),
      .wb_ack_i    (ack)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int g, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s dut%0d: observed %h expected %h", tag, g, obs, exp);
    end
  endtask

  // One access; lat = BUS cycle (1-based) in which the slave acks, 0 = never.
  // Called and returns on a falling edge with both bridges idle.
  task automatic xact(input logic [3:0] w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] rd, input int lat);
    int   done [2];
    bit   to   [2];
    int   kmax;
    logic [3:0] sel;
    sel  = (w != 4'h0) ? w : 4'hF;
    kmax = lat;
    for (int g = 0; g < 2; g++) begin
      to[g]   = !(lat != 0 && lat <= int'(tmo[g]));
      done[g] = to[g] ? int'(tmo[g]) : lat;
      if (done[g] > kmax) kmax = done[g];
      if (w == 4'h0) rd_m[g] = to[g] ? ErrData : rd;
    end
    kmax = kmax + 2;
    req   = 1'b1;
    we    = w;
    addr  = a;
    wdata = wd;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("req_stall", g, 32'(stall_o[g]), 32'd1);
      chk("req_cyc", g, 32'(cyc_o[g]), 32'd0);
    end
    @(negedge clk);
    // Core-side inputs must not matter once the access is registered.
    req   = 1'b0;
    we    = 4'($urandom);
    addr  = $urandom;
    wdata = $urandom;
    for (int k = 1; k <= kmax; k++) begin
      for (int g = 0; g < 2; g++) begin
        if (k <= done[g]) begin
          chk("bus_cyc", g, 32'(cyc_o[g]), 32'd1);
          chk("bus_stb", g, 32'(stb_o[g]), 32'd1);
          chk("bus_stall", g, 32'(stall_o[g]), 32'd1);
          chk("bus_adr", g, adr_o[g], a);
          chk("bus_dat", g, dat_o[g], wd);
          chk("bus_we", g, 32'(wbwe_o[g]), 32'(w != 4'h0));
          chk("bus_sel", g, 32'(sel_o[g]), 32'(sel));
        end else if (k == done[g] + 1) begin
          chk("resp_cyc", g, 32'(cyc_o[g]), 32'd0);
          chk("resp_stall", g, 32'(stall_o[g]), 32'd0);
          chk("resp_err", g, 32'(err_o[g]), 32'(to[g]));
          chk("resp_rdata", g, rdata_o[g], rd_m[g]);
        end else begin
          chk("idle_cyc", g, 32'(cyc_o[g]), 32'd0);
          chk("idle_err", g, 32'(err_o[g]), 32'd0);
          chk("idle_rdata", g, rdata_o[g], rd_m[g]);
        end
      end
      ack   = (k == lat);
      dat_i = (k == lat) ? rd : $urandom;
      @(negedge clk);
    end
    ack = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a1, a2, last_d;
    logic [3:0]  rw;
    int          ph;
    nchk   = 0;
    nfail  = 0;
    tmo[0] = TmoA;
    tmo[1] = TmoB;
    rd_m[0] = '0;
    rd_m[1] = '0;
    rst_n = 1'b0;
    req   = 1'b1;
    we    = 4'h0;
    addr  = 32'h0;
    wdata = 32'h0;
    dat_i = 32'h0;
    ack   = 1'b0;

    // Reset values; stall is masked even with a request pending.
    #2;
    for (int g = 0; g < 2; g++) begin
      chk("rst_stall", g, 32'(stall_o[g]), 32'd0);
      chk("rst_cyc", g, 32'(cyc_o[g]), 32'd0);
      chk("rst_stb", g, 32'(stb_o[g]), 32'd0);
      chk("rst_we", g, 32'(wbwe_o[g]), 32'd0);
      chk("rst_sel", g, 32'(sel_o[g]), 32'd0);
      chk("rst_adr", g, adr_o[g], 32'd0);
      chk("rst_dat", g, dat_o[g], 32'd0);
      chk("rst_rdata", g, rdata_o[g], 32'd0);
      chk("rst_err", g, 32'(err_o[g]), 32'd0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req   = 1'b0;
    @(negedge clk);

    // Directed accesses.
    xact(4'h0, 32'h0000_1000, $urandom, 32'hCAFE_0001, 1);
    xact(4'b0011, 32'h0000_2004, 32'h1234_5678, $urandom, 6);
    xact(4'h0, $urandom, $urandom, $urandom, 10);
    xact(4'h0, $urandom, $urandom, 32'h600D_0004, 4);
    xact(4'h0, $urandom, $urandom, 32'h600D_0008, 8);
    xact(4'b1000, $urandom, $urandom, $urandom, 0);

    // Back-to-back reads with the request held high and a zero-wait slave.
    a1    = 32'hA000_0010;
    a2    = 32'hA000_0020;
    last_d = '0;
    req   = 1'b1;
    we    = 4'h0;
    addr  = a1;
    ack   = 1'b1;
    #1;
    for (int j = 0; j < 7; j++) begin
      ph = j % 3;
      for (int g = 0; g < 2; g++) begin
        if (ph == 0) begin
          chk("b2b_idle_stall", g, 32'(stall_o[g]), 32'(j < 6));
          chk("b2b_idle_cyc", g, 32'(cyc_o[g]), 32'd0);
        end else if (ph == 1) begin
          chk("b2b_bus_cyc", g, 32'(cyc_o[g]), 32'd1);
          chk("b2b_bus_adr", g, adr_o[g], (j == 1) ? a1 : a2);
          chk("b2b_bus_sel", g, 32'(sel_o[g]), 32'hF);
        end else begin
          chk("b2b_resp_cyc", g, 32'(cyc_o[g]), 32'd0);
          chk("b2b_resp_stall", g, 32'(stall_o[g]), 32'd0);
          chk("b2b_resp_rdata", g, rdata_o[g], last_d);
        end
      end
      dat_i = $urandom;
      if (ph == 1) last_d = dat_i;
      if (j == 1) addr = a2;
      if (j == 5) req = 1'b0;
      @(negedge clk);
      #1;
    end
    ack = 1'b0;
    rd_m[0] = last_d;
    rd_m[1] = last_d;
    @(negedge clk);

    // Reset in the second BUS cycle.
    req  = 1'b1;
    we   = 4'h0;
    addr = 32'h0000_3000;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) chk("pre_rst_cyc", g, 32'(cyc_o[g]), 32'd1);
    #1;
    rst_n = 1'b0;
    req   = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      chk("midrst_cyc", g, 32'(cyc_o[g]), 32'd0);
      chk("midrst_stb", g, 32'(stb_o[g]), 32'd0);
      chk("midrst_err", g, 32'(err_o[g]), 32'd0);
      chk("midrst_rdata", g, rdata_o[g], 32'd0);
      chk("midrst_stall", g, 32'(stall_o[g]), 32'd0);
      rd_m[g] = '0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    req   = 1'b0;
    @(negedge clk);
    xact(4'h0, 32'h0000_3004, $urandom, 32'h5EED_0003, 3);

    // Randomized accesses.
    for (int i = 0; i < 24; i++) begin
      rw = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      xact(rw, $urandom, $urandom, $urandom, int'($urandom_range(0, 11)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
